// File: rtl/mod_sequencer.sv
// Sequential unsigned a mod b using an external WIDTH-bit ALU (restoring division, remainder only).
// Optional macro MOD_EARLY_EXIT_EN: finish in CHECK when a < b.
module mod_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b000;

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] dividend_reg, divisor_reg, rem_reg, rem_next;
    logic [WIDTH-1:0] alu_a_reg, alu_b_reg, result_reg;
    logic [CW-1:0]    cnt_reg;
    logic             div_zero_reg;
    logic [WIDTH-1:0] shifted;
    logic             last_iter;

    assign result   = result_reg;
    assign div_zero = div_zero_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        alu_a      = alu_a_reg;
        alu_b      = alu_b_reg;
        alu_op     = OP_NOP;
        busy       = 1'b0;
        done       = 1'b0;
        shifted    = {rem_reg[WIDTH-2:0], dividend_reg[WIDTH-1]};
        rem_next   = rem_reg;
        last_iter  = (cnt_reg == CW'(WIDTH - 1));
        case (state_reg)
            IDLE: begin
                if (start) state_next = CHECK;
            end
            CHECK: begin
                busy   = 1'b1;
                alu_op = OP_SUB;
`ifdef MOD_EARLY_EXIT_EN
                alu_a = dividend_reg;
                alu_b = divisor_reg;
                if (divisor_reg == '0 || !alu_cout) state_next = DONE;
                else                                state_next = RUN;
`else
                if (divisor_reg == '0) state_next = DONE;
                else                   state_next = RUN;
`endif
            end
            RUN: begin
                busy   = 1'b1;
                alu_op = OP_SUB;
                alu_a  = shifted;
                alu_b  = divisor_reg;
                // A shifted-out 1 means s exceeds the divisor even when the ALU reports a borrow.
                rem_next = (alu_cout || rem_reg[WIDTH-1]) ? alu_r : shifted;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            result_reg   <= '0;
            div_zero_reg <= 1'b0;
        end else begin
            alu_a_reg <= alu_a;
            alu_b_reg <= alu_b;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        dividend_reg <= a;
                        divisor_reg  <= b;
                        rem_reg      <= '0;
                        cnt_reg      <= '0;
                        div_zero_reg <= 1'b0;
                    end
                end
                CHECK: begin
                    if (divisor_reg == '0) begin
                        result_reg   <= dividend_reg;
                        div_zero_reg <= 1'b1;
                    end
`ifdef MOD_EARLY_EXIT_EN
                    else if (!alu_cout) begin
                        result_reg <= dividend_reg;
                    end
`endif
                end
                RUN: begin
                    rem_reg      <= rem_next;
                    dividend_reg <= {dividend_reg[WIDTH-2:0], 1'b0};
                    cnt_reg      <= cnt_reg + CW'(1);
                    if (last_iter) result_reg <= rem_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_sequencer.sv
// Directed bench for mod_sequencer with a behavioural 32-bit subtractor ALU.
module tb_mod_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] alu_a, alu_b, alu_r;
    logic [2:0]       alu_op;
    logic             alu_cout;
    logic             busy, done, div_zero;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   alu_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign alu_sum = (alu_op == 3'b110) ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1)
                                        : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_r    = alu_sum[WIDTH-1:0];
    assign alu_cout = alu_sum[WIDTH];

    mod_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r), .alu_cout(alu_cout),
        .busy(busy), .done(done), .result(result), .div_zero(div_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Launch one operation; n counts negedges after the accepting edge T.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input int exp_lat, input logic [31:0] exp_res, input logic exp_dz,
                          input int intr_n);
        int lat = 0;
        @(negedge clk);
        start = 1'b1; a = op_a; b = op_b;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 60 && lat == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 1) begin
                check({tag, "_busy_first"}, 64'(busy), 64'd1);
                check({tag, "_op_sub"}, 64'(alu_op), 64'h6);
            end
            if (intr_n != 0 && n == intr_n + 1) start = 1'b0;
            if (intr_n != 0 && n == intr_n) begin
                start = 1'b1; a = 32'd9; b = 32'd4;
            end
            if (n == exp_lat - 1) check({tag, "_busy_last"}, 64'(busy), 64'd1);
            if (done) lat = n;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(result), 64'(exp_res));
        check({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_result_held"}, 64'(result), 64'(exp_res));
        check({tag, "_op_idle"}, 64'(alu_op), 64'h0);
    endtask

    initial begin
        int seen_done;
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("m100_7", 32'd100, 32'd7, 34, 32'd2, 1'b0, 0);
        run_op("m5_0", 32'd5, 32'd0, 2, 32'd5, 1'b1, 0);
        run_op("big_div", 32'hFFFF_FFFF, 32'h8000_0000, 34, 32'h7FFF_FFFF, 1'b0, 0);
`ifdef MOD_EARLY_EXIT_EN
        run_op("m3_10", 32'd3, 32'd10, 2, 32'd3, 1'b0, 0);
`else
        run_op("m3_10", 32'd3, 32'd10, 34, 32'd3, 1'b0, 0);
`endif
        run_op("ignore_start", 32'd100, 32'd7, 34, 32'd2, 1'b0, 10);
        run_op("equal", 32'd1000, 32'd1000, 34, 32'd0, 1'b0, 0);
        run_op("m_hex", 32'h1234_5678, 32'h0000_1000, 34, 32'h0000_0678, 1'b0, 0);

        // Abort an operation with reset at T+15.
        @(negedge clk);
        start = 1'b1; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_div_zero", 64'(div_zero), 64'd0);
        check("abort_alu_a", 64'(alu_a), 64'd0);
        check("abort_alu_b", 64'(alu_b), 64'd0);
        check("abort_alu_op", 64'(alu_op), 64'd0);
        reset_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        run_op("after_rst", 32'd20, 32'd6, 34, 32'd2, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
